// File: rtl/usrt_tx_engine.sv
// ---------------------------------------------------------------------------
// usrt_tx_engine
//   USRT transmit engine. Words arriving from the APB write path are queued
//   in a small FIFO and serialised onto Rx, one frame per word:
//     start (1), DATA_W data bits LSB first, optional even parity, stop (0).
//   The line idles at 0. An internal baud counter produces the one-cycle
//   bit-period tick uClk; the framing FSM and Rx only move on that tick.
//
//   Optional feature macro: USRT_TX_PARITY_EN
//     defined   -> a PARITY state sends ^data after the last data bit
//     undefined -> no parity state or logic; frame is 1+DATA_W+STOP_BITS bits
// ---------------------------------------------------------------------------
module usrt_tx_engine #(
  parameter int DATA_W     = 8,   // data bits per frame (1..16)
  parameter int DIV        = 80,  // pClk cycles per bit period (>=2)
  parameter int FIFO_DEPTH = 4,   // TX FIFO entries (power of 2, >=2)
  parameter int STOP_BITS  = 1    // stop bits per frame (1 or 2)
) (
  input  logic                              pClk,
  input  logic                              pReset,
  input  logic                              en,
  input  logic                              wr_valid,
  input  logic [DATA_W-1:0]                 wr_data,
  output logic                              wr_ready,
  output logic                              Rx,
  output logic                              uClk,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  // Derived widths. The bit index is kept at least one bit wide so that a
  // one-bit data word still elaborates cleanly.
  localparam int CNT_W = $clog2(DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  // Frame state encoding
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef USRT_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  // Baud generator
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick;

  // Framing FSM and serial datapath
  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] shift_nxt;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_q, stop_d;
  logic              rx_q, rx_d;
  logic              busy_q, busy_d;
  logic              start_frame;
`ifdef USRT_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  // TX FIFO
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] head;
  logic              push;
  logic              pop;

  // Readiness comes purely from the registered level, so a word offered at
  // full is refused even when the FSM pops in the same cycle.
  assign wr_ready  = (level_q != LVL_FULL);
  assign push      = wr_valid && wr_ready;
  assign head      = mem_q[rd_ptr_q];
  assign tick      = (cnt_q == CNT_MAX);
  assign shift_nxt = shift_q >> 1;

  assign uClk       = tick;
  assign Rx         = rx_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;

  // Baud counter: free-runs 0..DIV-1 while enabled, parked at 0 otherwise so
  // the first tick after re-enable lands a full bit period later.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Framing FSM: decides the next line level and pops the FIFO on ticks.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    stop_d      = stop_q;
    rx_d        = rx_q;
    pop         = 1'b0;
    start_frame = 1'b0;
`ifdef USRT_TX_PARITY_EN
    par_d       = par_q;
`endif

    if (!en) begin
      state_d = IDLE;
      rx_d    = 1'b0;
    end else if (tick) begin
      case (state_q)
        IDLE: begin
          if (level_q != '0) begin
            start_frame = 1'b1;
          end else begin
            rx_d = 1'b0;
          end
        end
        START: begin
          rx_d    = shift_q[0];
          idx_d   = '0;
          state_d = DATA;
        end
        DATA: begin
          if (idx_q == IDX_LAST) begin
`ifdef USRT_TX_PARITY_EN
            rx_d    = par_q;
            state_d = PARITY;
`else
            rx_d    = 1'b0;
            stop_d  = 1'b0;
            state_d = STOP;
`endif
          end else begin
            shift_d = shift_nxt;
            rx_d    = shift_nxt[0];
            idx_d   = idx_q + IDX_W'(1);
          end
        end
`ifdef USRT_TX_PARITY_EN
        PARITY: begin
          rx_d    = 1'b0;
          stop_d  = 1'b0;
          state_d = STOP;
        end
`endif
        STOP: begin
          if (stop_q == STOP_LAST) begin
            // A queued word starts straight after the last stop bit, so
            // back-to-back frames carry no extra idle period.
            if (level_q != '0) begin
              start_frame = 1'b1;
            end else begin
              rx_d    = 1'b0;
              state_d = IDLE;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
        default: begin
          rx_d    = 1'b0;
          state_d = IDLE;
        end
      endcase

      if (start_frame) begin
        pop     = 1'b1;
        shift_d = head;
        rx_d    = 1'b1;
        state_d = START;
`ifdef USRT_TX_PARITY_EN
        par_d   = ^head;
`endif
      end
    end

    busy_d = (state_d != IDLE);
  end

  // FIFO bookkeeping: pointers wrap naturally on the power-of-two depth and
  // the level tracks push/pop exactly.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  // FIFO storage: data only, no reset needed since level gates every read.
  always_ff @(posedge pClk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      cnt_q    <= '0;
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      rx_q     <= 1'b0;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
`ifdef USRT_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      rx_q     <= rx_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
`ifdef USRT_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_usrt_tx_engine.sv
// ---------------------------------------------------------------------------
// tb_usrt_tx_engine
//   Directed bench for usrt_tx_engine (DATA_W=8, DIV=4, FIFO_DEPTH=4).
//   A second instance uses STOP_BITS=2. Expected frames follow
//   USRT_TX_PARITY_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_usrt_tx_engine;

  localparam int DIV = 4;
`ifdef USRT_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LEN1 = 1 + 8 + P + 1;
  localparam int LEN2 = 1 + 8 + P + 2;

  logic       pClk = 1'b0;
  logic       pReset;
  logic       en, wr_valid, wr_ready, rx, uclk, busy;
  logic [7:0] wr_data;
  logic [2:0] level;
  logic       en2, wr_valid2, wr_ready2, rx2, uclk2, busy2;
  logic [7:0] wr_data2;
  logic [2:0] level2;

  int vectors     = 0;
  int miscompares = 0;

  always #5 pClk = ~pClk;

  usrt_tx_engine #(.DATA_W(8), .DIV(DIV), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
    .pClk(pClk), .pReset(pReset), .en(en), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .Rx(rx), .uClk(uclk), .busy(busy), .fifo_level(level)
  );

  usrt_tx_engine #(.DATA_W(8), .DIV(DIV), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .pClk(pClk), .pReset(pReset), .en(en2), .wr_valid(wr_valid2), .wr_data(wr_data2),
    .wr_ready(wr_ready2), .Rx(rx2), .uClk(uclk2), .busy(busy2), .fifo_level(level2)
  );

  task automatic tick();
    @(posedge pClk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic [7:0] word);
    if (sel == 0) begin
      wr_valid = 1'b1; wr_data = word;
    end else begin
      wr_valid2 = 1'b1; wr_data2 = word;
    end
    tick();
    wr_valid  = 1'b0;
    wr_valid2 = 1'b0;
  endtask

  function automatic logic sel_rx(input int sel);
    return (sel == 0) ? rx : rx2;
  endfunction

  function automatic logic [15:0] frame_of(input logic [7:0] w);
    logic [15:0] f;
    f    = '0;
    f[0] = 1'b1;
    for (int i = 0; i < 8; i++) f[1+i] = w[i];
    if (P == 1) f[9] = ^w;
    return f;
  endfunction

  task automatic wait_start(input int sel, input string tag, output int n);
    n = 0;
    while (sel_rx(sel) !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    checkOutput({tag, " start seen"}, 32'(n < 64), 32'd1);
  endtask

  task automatic check_frame(input int sel, input logic [15:0] f, input int len,
                             input int skip, input string tag);
    for (int c = skip; c < len * DIV; c++) begin
      checkOutput($sformatf("%s bit%0d", tag, c / DIV), 32'(sel_rx(sel)), 32'(f[c / DIV]));
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] words [5];
    int n;

    pReset = 1'b0;
    en = 1'b0; wr_valid = 1'b0; wr_data = '0;
    en2 = 1'b0; wr_valid2 = 1'b0; wr_data2 = '0;
    repeat (2) tick();

    // reset values
    checkOutput("reset rx", 32'(rx), 32'd0);
    checkOutput("reset uclk", 32'(uclk), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("reset level", 32'(level), 32'd0);
    checkOutput("reset rx2", 32'(rx2), 32'd0);

    pReset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("uclk held while disabled", 32'(uclk), 32'd0);
    end

    // single word 8'hA5, hand-built line sequence 1,1,0,1,0,0,1,0,1,(0),0
    en = 1'b1;
    applyStimulus(0, 8'hA5);
    checkOutput("a5 level after push", 32'(level), 32'd1);
    checkOutput("a5 busy before start", 32'(busy), 32'd0);
    wait_start(0, "a5", n);
    checkOutput("a5 start latency", 32'(n), 32'd3);
    checkOutput("a5 busy in frame", 32'(busy), 32'd1);
    check_frame(0, 16'h014B, LEN1, 0, "a5");
    checkOutput("a5 idle rx", 32'(rx), 32'd0);
    checkOutput("a5 idle busy", 32'(busy), 32'd0);
    checkOutput("a5 idle level", 32'(level), 32'd0);
    n = 0;
    for (int i = 0; i < 2 * DIV; i++) begin
      if (uclk === 1'b1) n++;
      tick();
    end
    checkOutput("uclk ticks per 2 periods", 32'(n), 32'd2);
    checkOutput("idle rx stays low", 32'(rx), 32'd0);

    // fill the FIFO while disabled; fifth word refused
    en = 1'b0;
    tick();
    words[0] = 8'h11; words[1] = 8'h80; words[2] = 8'h33; words[3] = 8'hC4; words[4] = 8'h55;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("fill wr_ready %0d", i), 32'(wr_ready), 32'(i < 4));
      wr_valid = 1'b1; wr_data = words[i];
      tick();
    end
    wr_valid = 1'b0;
    checkOutput("fill level", 32'(level), 32'd4);
    checkOutput("fill wr_ready full", 32'(wr_ready), 32'd0);

    // enable; offer 8'h01 during the pop tick, then again next cycle
    en = 1'b1;
    n = 0;
    while (uclk !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    checkOutput("first tick after enable", 32'(n), 32'd3);
    wr_valid = 1'b1; wr_data = 8'h01;
    tick();
    checkOutput("full push refused level", 32'(level), 32'd3);
    checkOutput("wr_ready after pop", 32'(wr_ready), 32'd1);
    checkOutput("q0 start rx", 32'(rx), 32'd1);
    tick();
    wr_valid = 1'b0;
    checkOutput("retry push accepted", 32'(level), 32'd4);
    check_frame(0, frame_of(8'h11), LEN1, 1, "q0");
    check_frame(0, frame_of(8'h80), LEN1, 0, "q1");
    check_frame(0, frame_of(8'h33), LEN1, 0, "q2");
    check_frame(0, frame_of(8'hC4), LEN1, 0, "q3");
    check_frame(0, frame_of(8'h01), LEN1, 0, "q4");
    checkOutput("queue drained rx", 32'(rx), 32'd0);
    checkOutput("queue drained busy", 32'(busy), 32'd0);
    checkOutput("queue drained level", 32'(level), 32'd0);

    // drop enable at data bit 3 of 8'hFF
    en = 1'b0;
    tick();
    applyStimulus(0, 8'hFF);
    applyStimulus(0, 8'h66);
    checkOutput("abort level queued", 32'(level), 32'd2);
    en = 1'b1;
    wait_start(0, "ff", n);
    checkOutput("ff start latency", 32'(n), 32'(DIV));
    check_frame(0, frame_of(8'hFF), 4, 0, "ff");
    checkOutput("ff data bit3", 32'(rx), 32'd1);
    en = 1'b0;
    tick();
    checkOutput("abort rx", 32'(rx), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort uclk", 32'(uclk), 32'd0);
    checkOutput("abort level kept", 32'(level), 32'd1);
    repeat (5) tick();
    checkOutput("abort rx stays low", 32'(rx), 32'd0);
    en = 1'b1;
    wait_start(0, "66", n);
    checkOutput("66 start latency", 32'(n), 32'(DIV));
    check_frame(0, frame_of(8'h66), LEN1, 0, "66");
    checkOutput("66 idle level", 32'(level), 32'd0);

    // asynchronous reset in the middle of a frame
    applyStimulus(0, 8'h3C);
    applyStimulus(0, 8'h5A);
    wait_start(0, "3c", n);
    repeat (6) tick();
    checkOutput("pre-reset busy", 32'(busy), 32'd1);
    checkOutput("pre-reset level", 32'(level), 32'd1);
    pReset = 1'b0;
    #1;
    checkOutput("async reset rx", 32'(rx), 32'd0);
    checkOutput("async reset uclk", 32'(uclk), 32'd0);
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("async reset level", 32'(level), 32'd0);
    en = 1'b0;
    tick();
    pReset = 1'b1;
    tick();

    // two stop bits, two back-to-back frames
    en2 = 1'b1;
    applyStimulus(1, 8'h80);
    applyStimulus(1, 8'h81);
    wait_start(1, "s2", n);
    check_frame(1, frame_of(8'h80), LEN2, 0, "s2 80");
    check_frame(1, frame_of(8'h81), LEN2, 0, "s2 81");
    checkOutput("s2 idle rx", 32'(rx2), 32'd0);
    checkOutput("s2 idle busy", 32'(busy2), 32'd0);
    checkOutput("s2 idle level", 32'(level2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
